// File: rtl/booth_mul_seq_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
package booth_mul_seq_pkg;

  // Default operand width; the product is twice as wide.
  localparam int DEF_WIDTH = 32;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Booth recoding of {q[0], q_-1}: 01 adds M, 10 subtracts M, 00/11 do nothing.
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;

endpackage

// File: rtl/booth_mul_seq_add_sub.sv
// Combinational (WIDTH+1)-bit ripple-carry add/subtract stage.
// sum = a + (sub ? ~b : b) + sub; the carry out of the top bit is dropped.
module booth_add_sub #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);

  logic             carry;
  logic [WIDTH-1:0] b_eff;

  // Ripple the carry bit by bit, seeded with sub so that subtraction becomes
  // a + ~b + 1.
  always_comb begin
    // NOTE: every variable gets a value before any branch or loop so no latch is inferred.
    sum   = '0;
    carry = sub;
    b_eff = b ^ {WIDTH{sub}};
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b_eff[i] ^ carry;
      carry  = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
    end
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: WIDTH x WIDTH signed -> 2*WIDTH signed,
// one Booth step per clock. The product appears on hi/lo with a one-cycle
// done pulse and is held until the next accepted start.
module booth_mul_seq
  import booth_mul_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6          // 2**CNT_W must exceed WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH:0]   acc;      // one guard bit so A +/- M cannot overflow, even for M = -2^(WIDTH-1)
  logic [WIDTH:0]   m_reg;    // sign-extended multiplicand
  logic [WIDTH-1:0] q_reg;    // multiplier, shifted out as product low half forms
  logic             q_m1;     // Booth q_-1 bit
  logic [CNT_W-1:0] count;

  logic [1:0]       pair;
  logic             do_sub;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_next;

  assign pair   = {q_reg[0], q_m1};
  assign do_sub = (pair == PAIR_SUB);

  booth_add_sub #(
    .WIDTH (WIDTH + 1)
  ) u_add_sub (
    .a   (acc),
    .b   (m_reg),
    .sub (do_sub),
    .sum (sum)
  );

  // Accumulator value after this cycle's add/subtract, before the shift.
  always_comb begin
    acc_next = acc;
    if (pair == PAIR_ADD || pair == PAIR_SUB) acc_next = sum;
  end

  // Controller, counter and {A, Q, q_-1} shift register with registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (clr) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      acc   <= '0;
      m_reg <= '0;
      q_reg <= '0;
      q_m1  <= 1'b0;
      count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc   <= '0;
            m_reg <= {multiplicand[WIDTH-1], multiplicand};
            q_reg <= multiplier;
            q_m1  <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Arithmetic right shift of {A, Q, q_-1}, replicating A's sign bit.
          acc   <= {acc_next[WIDTH], acc_next[WIDTH:1]};
          q_reg <= {acc_next[0], q_reg[WIDTH-1:1]};
          q_m1  <= q_reg[0];
          count <= count + CNT_W'(1);
          if (count == LAST_STEP) begin
            busy  <= 1'b0;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          hi    <= acc[WIDTH-1:0];
          lo    <= q_reg;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed cases from the test plan
// plus random back-to-back operands, checked against signed 64-bit arithmetic.
module tb_booth_mul_seq;

  localparam int W = 32;
  localparam int LATENCY = 33;
  localparam int BUSY_CYCLES = 32;

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;
  int cyc;
  int busy_cnt;

  booth_mul_seq dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  // Reference: plain signed 64-bit multiplication.
  function automatic logic [63:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    longint p;
    p = longint'($signed(m)) * longint'($signed(q));
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample #1 after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cnt++;
  endtask

  // Present operands with start high for the next edge; optionally keep start high.
  task automatic launch(input logic [W-1:0] m, input logic [W-1:0] q, input bit hold);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk);
    #1;
    cyc      = 0;
    busy_cnt = busy ? 1 : 0;
    if (!hold) start = 1'b0;
  endtask

  // Wait (bounded) for done, then check latency, busy length and product.
  task automatic wait_done(input string tag, input logic [63:0] exp);
    while (!done && cyc < 100) step();
    check({tag, "_latency"}, 64'(cyc), 64'(LATENCY));
    check({tag, "_busy"}, 64'(busy_cnt), 64'(BUSY_CYCLES));
    check({tag, "_product"}, {hi, lo}, exp);
  endtask

  initial begin
    logic [W-1:0] rm, rq;
    bit saw_done;

    clr = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);

    // 3 x 5 with latency and busy-length checks, then one-cycle done pulse.
    launch(32'd3, 32'd5, 1'b0);
    wait_done("m3x5", ref_mul(32'd3, 32'd5));
    check("m3x5_const", {hi, lo}, 64'h0000_0000_0000_000F);
    step();
    check("done_pulse_width", 64'(done), 64'd0);
    check("hold_after_done", {hi, lo}, 64'h0000_0000_0000_000F);

    launch(32'hFFFF_FFF9, 32'd6, 1'b0);
    wait_done("neg7x6", ref_mul(32'hFFFF_FFF9, 32'd6));
    launch(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done("neg1x1", ref_mul(32'hFFFF_FFFF, 32'd1));
    launch(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done("minxmin", ref_mul(32'h8000_0000, 32'h8000_0000));
    check("minxmin_const", {hi, lo}, 64'h4000_0000_0000_0000);
    launch(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    wait_done("maxxmin", ref_mul(32'h7FFF_FFFF, 32'h8000_0000));

    // Reload 3x5, then start 9x9 and disturb operands/start mid-run.
    step();
    launch(32'd3, 32'd5, 1'b0);
    wait_done("prime3x5", ref_mul(32'd3, 32'd5));
    step();
    launch(32'd9, 32'd9, 1'b0);
    repeat (9) step();
    multiplicand = 32'd1234; multiplier = 32'd777; start = 1'b1;
    step();
    start = 1'b0;
    check("hold_during_run", {hi, lo}, 64'h0000_0000_0000_000F);
    wait_done("ignored_start", ref_mul(32'd9, 32'd9));

    // Abort with clr mid-run; done must never pulse afterwards.
    step();
    launch(32'd12345, 32'd678, 1'b0);
    repeat (14) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_hilo", {hi, lo}, 64'd0);
    saw_done = done;
    repeat (40) begin
      step();
      if (done) saw_done = 1'b1;
    end
    check("clr_no_done", 64'(saw_done), 64'd0);
    launch(32'd2, 32'd2, 1'b0);
    wait_done("after_clr", ref_mul(32'd2, 32'd2));

    // clr together with start: no operation begins.
    step();
    clr = 1'b1;
    launch(32'd7, 32'd7, 1'b0);
    clr = 1'b0;
    check("clr_wins_busy", 64'(busy), 64'd0);

    // Start held high through DONE: accepted only in the following IDLE cycle.
    step();
    launch(32'd11, 32'd13, 1'b1);
    wait_done("held_first", ref_mul(32'd11, 32'd13));
    launch(32'hFFFF_FF00, 32'd100, 1'b0);
    wait_done("held_b2b", ref_mul(32'hFFFF_FF00, 32'd100));

    // Random operands, each launched in the cycle done is high.
    for (int i = 0; i < 8; i++) begin
      rm = $urandom;
      rq = $urandom;
      launch(rm, rq, 1'b0);
      wait_done($sformatf("rand%0d", i), ref_mul(rm, rq));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
